// File: rtl/ram8_pkg.sv
// Shared definitions for the 8-word RAM initiator: op codes, depth and FSM states.
package ram8_pkg;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;
    localparam logic [1:0] OP_CHECK = 2'd3;

    localparam int DEPTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_FILL      = 3'd4,
        ST_CHECK     = 3'd5,
        ST_RESP      = 3'd6
    } state_t;

endpackage

// File: rtl/ram8_initiator.sv
// Command-driven initiator for an 8x8 RAM. Accepts one command at a time,
// sequences write/read strobes (single word or whole array), absorbs the
// RAM's one-cycle read latency and returns one response per command.
// Every output is a flop loaded from the next-state decode, so nothing on
// cmd_*/rsp_ready reaches an output combinationally.
module ram8_initiator
    import ram8_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              wr_enb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] data_in,
    output logic              rd_enb,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] data_out
);

    localparam int         APAD     = ADDR_W - 3;
    localparam int         DPAD     = DATA_W - 4;
    localparam logic [2:0] PTR_LAST = 3'(DEPTH - 1);

    state_t              r_state;
    logic [2:0]          r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [2:0]          r_ptr;
    logic                r_tail;     // CHECK: all reads issued, last compare pending
    logic                r_cmp_vld;  // data_out holds a CHECK read to compare
    logic [3:0]          r_cnt;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic                r_wr_enb;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_rd_enb;
    logic [ADDR_W-1:0]   r_rd_addr;

    state_t              w_state_nxt;
    logic [2:0]          w_addr_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [2:0]          w_ptr_nxt;
    logic                w_tail_nxt;
    logic                w_cmp_vld_nxt;
    logic [3:0]          w_cnt_nxt;
    logic                w_mis;
    logic [3:0]          w_cnt_inc;
    logic [DATA_W-1:0]   w_rsp_data_nxt;
    logic                w_rsp_err_nxt;
    logic                w_wr_enb_nxt;
    logic [ADDR_W-1:0]   w_wr_addr_nxt;
    logic [DATA_W-1:0]   w_data_in_nxt;
    logic                w_rd_enb_nxt;
    logic [ADDR_W-1:0]   w_rd_addr_nxt;

    // Next-state, datapath and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_ptr_nxt      = r_ptr;
        w_tail_nxt     = r_tail;
        w_cmp_vld_nxt  = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_err_nxt  = r_rsp_err;
        w_wr_enb_nxt   = 1'b0;
        w_wr_addr_nxt  = {ADDR_W{1'b0}};
        w_data_in_nxt  = {DATA_W{1'b0}};
        w_rd_enb_nxt   = 1'b0;
        w_rd_addr_nxt  = {ADDR_W{1'b0}};

        w_mis     = r_cmp_vld && (data_out != r_data);
        w_cnt_inc = r_cnt + {3'b000, w_mis};

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_addr_nxt = cmd_addr;
                    w_data_nxt = cmd_data;
                    w_ptr_nxt  = 3'd0;
                    w_tail_nxt = 1'b0;
                    w_cnt_nxt  = 4'd0;
                    case (cmd_op)
                        OP_WRITE: w_state_nxt = ST_WRITE;
                        OP_READ:  w_state_nxt = ST_READ;
                        OP_FILL:  w_state_nxt = ST_FILL;
                        OP_CHECK: w_state_nxt = ST_CHECK;
                        default:  w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_state_nxt    = ST_RESP;
                w_rsp_data_nxt = r_data;
                w_rsp_err_nxt  = 1'b0;
            end
            ST_READ: begin
                w_state_nxt = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                w_state_nxt    = ST_RESP;
                w_rsp_data_nxt = data_out;
                w_rsp_err_nxt  = 1'b0;
            end
            ST_FILL: begin
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt    = ST_RESP;
                    w_rsp_data_nxt = r_data;
                    w_rsp_err_nxt  = 1'b0;
                end else begin
                    w_ptr_nxt = r_ptr + 3'd1;
                end
            end
            ST_CHECK: begin
                // A read issued this cycle returns next cycle.
                w_cmp_vld_nxt = !r_tail;
                w_cnt_nxt     = w_cnt_inc;
                if (r_tail) begin
                    w_state_nxt    = ST_RESP;
                    w_rsp_data_nxt = {{DPAD{1'b0}}, w_cnt_inc};
                    w_rsp_err_nxt  = (w_cnt_inc != 4'd0);
                end else if (r_ptr == PTR_LAST) begin
                    w_tail_nxt = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt    = ST_IDLE;
                    w_rsp_data_nxt = {DATA_W{1'b0}};
                    w_rsp_err_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt == ST_WRITE) begin
            w_wr_enb_nxt  = 1'b1;
            w_wr_addr_nxt = {{APAD{1'b0}}, w_addr_nxt};
            w_data_in_nxt = w_data_nxt;
        end else if (w_state_nxt == ST_FILL) begin
            w_wr_enb_nxt  = 1'b1;
            w_wr_addr_nxt = {{APAD{1'b0}}, w_ptr_nxt};
            w_data_in_nxt = w_data_nxt;
        end else begin
            w_wr_enb_nxt  = 1'b0;
        end

        if (w_state_nxt == ST_READ) begin
            w_rd_enb_nxt  = 1'b1;
            w_rd_addr_nxt = {{APAD{1'b0}}, w_addr_nxt};
        end else if ((w_state_nxt == ST_CHECK) && !w_tail_nxt) begin
            w_rd_enb_nxt  = 1'b1;
            w_rd_addr_nxt = {{APAD{1'b0}}, w_ptr_nxt};
        end else begin
            w_rd_enb_nxt  = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= 3'd0;
            r_data      <= {DATA_W{1'b0}};
            r_ptr       <= 3'd0;
            r_tail      <= 1'b0;
            r_cmp_vld   <= 1'b0;
            r_cnt       <= 4'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {DATA_W{1'b0}};
            r_rsp_err   <= 1'b0;
            r_wr_enb    <= 1'b0;
            r_wr_addr   <= {ADDR_W{1'b0}};
            r_data_in   <= {DATA_W{1'b0}};
            r_rd_enb    <= 1'b0;
            r_rd_addr   <= {ADDR_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_ptr       <= w_ptr_nxt;
            r_tail      <= w_tail_nxt;
            r_cmp_vld   <= w_cmp_vld_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_wr_enb    <= w_wr_enb_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_data_in   <= w_data_in_nxt;
            r_rd_enb    <= w_rd_enb_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign wr_enb    = r_wr_enb;
    assign wr_addr   = r_wr_addr;
    assign data_in   = r_data_in;
    assign rd_enb    = r_rd_enb;
    assign rd_addr   = r_rd_addr;

endmodule
